zcd_frame_ctrl: RTL and testbench

Frame-level controller sitting downstream of the ZCD pulse-interval decoder in the `sclk_3mhz` domain. It gates the decoder, hunts the decoded symbol stream for a preamble, collects a fixed-length payload MSB-first, and supervises inter-symbol gaps with a timeout. It then hands each completed frame to a consumer over a valid/ready handshake, reporting aborted frames and dropped symbols.

---
 rtl/zcd_frame_ctrl.sv | 173 +++++++++++++++++
 tb/tb_zcd_frame_ctrl.sv | 439 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zcd_frame_ctrl.sv
// zcd_frame_ctrl: frame controller behind the ZCD pulse-interval decoder.
// It gates the decoder and hunts for a preamble. It then collects an
// MSB-first payload under an inter-symbol gap timeout, and hands each
// finished frame out over valid/ready.
// Ports: sclk_3mhz, reset_n (async, active-low), enable,
//   sym_valid/sym_bit/sym_err (decoder input),
//   dec_en, frame_data/frame_valid/frame_ready, frame_err,
//   drop_cnt (symbols dropped while holding a frame), state.
module zcd_frame_ctrl #(
  parameter int DATA_BITS = 8,
  parameter int PRE_LEN = 4,
  parameter logic [PRE_LEN-1:0] PREAMBLE = 4'b0101,
  parameter int TIMEOUT = 31
) (
  input  logic                 sclk_3mhz,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic                 sym_valid,
  input  logic                 sym_bit,
  input  logic                 sym_err,
  output logic                 dec_en,
  output logic [DATA_BITS-1:0] frame_data,
  output logic                 frame_valid,
  input  logic                 frame_ready,
  output logic                 frame_err,
  output logic [7:0]           drop_cnt,
  output logic [1:0]           state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HUNT    = 2'd1,
    PAYLOAD = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [4:0] LAST_BIT = 5'(DATA_BITS - 1);
  localparam logic [7:0] TMO      = 8'(TIMEOUT);

  state_t               state_q;
  logic                 dec_en_q;
  logic [DATA_BITS-1:0] frame_data_q;
  logic                 frame_valid_q;
  logic                 frame_err_q;
  logic [7:0]           drop_cnt_q;
  logic [PRE_LEN-1:0]   pre_sr_q;
  logic [DATA_BITS-1:0] data_sr_q;
  logic [4:0]           bit_cnt_q;
  logic [7:0]           gap_cnt_q;

  logic                 good;
  logic                 bad;
  logic [PRE_LEN-1:0]   pre_d;
  logic [DATA_BITS-1:0] data_d;
  logic [7:0]           gap_d;
  logic [7:0]           drop_d;

  assign good   = sym_valid & ~sym_err;
  assign bad    = sym_valid & sym_err;
  assign pre_d  = {pre_sr_q[PRE_LEN-2:0], sym_bit};
  assign data_d = {data_sr_q[DATA_BITS-2:0], sym_bit};
  assign gap_d  = (gap_cnt_q == TMO) ? gap_cnt_q
                                     : gap_cnt_q + 8'd1;
  assign drop_d = (drop_cnt_q == 8'hFF) ? drop_cnt_q
                                        : drop_cnt_q + 8'd1;

  always_ff @(posedge sclk_3mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      dec_en_q      <= 1'b0;
      frame_data_q  <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      drop_cnt_q    <= '0;
      pre_sr_q      <= '0;
      data_sr_q     <= '0;
      bit_cnt_q     <= '0;
      gap_cnt_q     <= '0;
    end else begin
      frame_err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (enable) begin
            state_q  <= HUNT;
            dec_en_q <= 1'b1;
          end
        end
        HUNT: begin
          if (!enable) begin
            state_q   <= IDLE;
            dec_en_q  <= 1'b0;
            pre_sr_q  <= '0;
            data_sr_q <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
          end else if (bad) begin
            pre_sr_q <= '0;
          end else if (good) begin
            if (pre_d == PREAMBLE) begin
              state_q   <= PAYLOAD;
              pre_sr_q  <= '0;
              bit_cnt_q <= '0;
              gap_cnt_q <= '0;
            end else begin
              pre_sr_q <= pre_d;
            end
          end
        end
        PAYLOAD: begin
          if (!enable) begin
            state_q   <= IDLE;
            dec_en_q  <= 1'b0;
            pre_sr_q  <= '0;
            data_sr_q <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
          end else if (bad) begin
            state_q     <= HUNT;
            frame_err_q <= 1'b1;
            data_sr_q   <= '0;
            bit_cnt_q   <= '0;
            gap_cnt_q   <= '0;
          end else if (good) begin
            gap_cnt_q <= '0;
            if (bit_cnt_q == LAST_BIT) begin
              state_q       <= DONE;
              dec_en_q      <= 1'b0;
              frame_data_q  <= data_d;
              frame_valid_q <= 1'b1;
              data_sr_q     <= '0;
              bit_cnt_q     <= '0;
            end else begin
              data_sr_q <= data_d;
              bit_cnt_q <= bit_cnt_q + 5'd1;
            end
          end else if (gap_d == TMO) begin
            // Abort on the idle cycle whose count reaches TIMEOUT.
            state_q     <= HUNT;
            frame_err_q <= 1'b1;
            data_sr_q   <= '0;
            bit_cnt_q   <= '0;
            gap_cnt_q   <= '0;
          end else begin
            gap_cnt_q <= gap_d;
          end
        end
        DONE: begin
          // In-flight decoder symbols are dropped and counted.
          if (sym_valid) begin
            drop_cnt_q <= drop_d;
          end
          if (frame_valid_q && frame_ready) begin
            frame_valid_q <= 1'b0;
            if (enable) begin
              state_q  <= HUNT;
              dec_en_q <= 1'b1;
            end else begin
              state_q <= IDLE;
            end
          end
        end
      endcase
    end
  end

  assign dec_en      = dec_en_q;
  assign frame_data  = frame_data_q;
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;
  assign drop_cnt    = drop_cnt_q;
  assign state       = state_q;

endmodule

// File: tb/tb_zcd_frame_ctrl.sv
// tb_zcd_frame_ctrl: directed self-checking bench for zcd_frame_ctrl.
// Each scenario task drives symbols and checks outputs after the edge.
module tb_zcd_frame_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       sym_valid;
  logic       sym_bit;
  logic       sym_err;
  logic       dec_en;
  logic [7:0] frame_data;
  logic       frame_valid;
  logic       frame_ready;
  logic       frame_err;
  logic [7:0] drop_cnt;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;
  int err_pulses = 0;

  zcd_frame_ctrl dut (
    .sclk_3mhz  (clk),
    .reset_n    (rst_n),
    .enable     (enable),
    .sym_valid  (sym_valid),
    .sym_bit    (sym_bit),
    .sym_err    (sym_err),
    .dec_en     (dec_en),
    .frame_data (frame_data),
    .frame_valid(frame_valid),
    .frame_ready(frame_ready),
    .frame_err  (frame_err),
    .drop_cnt   (drop_cnt),
    .state      (state)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err === 1'b1) err_pulses++;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic send_sym(input logic b, input logic e);
    sym_valid = 1'b1;
    sym_bit   = b;
    sym_err   = e;
    cyc();
    sym_valid = 1'b0;
    sym_bit   = 1'b0;
    sym_err   = 1'b0;
  endtask

  task automatic send_pre();
    send_sym(1'b0, 1'b0);
    send_sym(1'b1, 1'b0);
    send_sym(1'b0, 1'b0);
    send_sym(1'b1, 1'b0);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_sym(v[i], 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    enable = 1'b0;
    sym_valid = 1'b0;
    sym_bit = 1'b0;
    sym_err = 1'b0;
    frame_ready = 1'b0;
    #12;
    checks++;
    if (state !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: got %0d want 0", state);
    end
    checks++;
    if ({dec_en, frame_valid, frame_err} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got %b want 000",
               {dec_en, frame_valid, frame_err});
    end
    checks++;
    if ({frame_data, drop_cnt} !== 16'h0000) begin
      errors++;
      $display("FAIL reset_data: got %h want 0000",
               {frame_data, drop_cnt});
    end
    rst_n = 1'b1;
    idle(2);
    checks++;
    if (state !== 2'd0) begin
      errors++;
      $display("FAIL idle_hold: got %0d want 0", state);
    end
  endtask

  task automatic test_basic();
    int e0;
    e0 = err_pulses;
    frame_ready = 1'b1;
    enable = 1'b1;
    cyc();
    checks++;
    if (state !== 2'd1 || dec_en !== 1'b1) begin
      errors++;
      $display("FAIL basic_hunt: got st=%0d en=%b want 1/1",
               state, dec_en);
    end
    send_pre();
    checks++;
    if (state !== 2'd2) begin
      errors++;
      $display("FAIL basic_payload: got %0d want 2", state);
    end
    send_sym(1, 0); send_sym(0, 0); send_sym(1, 0);
    send_sym(0, 0); send_sym(0, 0); send_sym(1, 0);
    send_sym(0, 0);
    checks++;
    if (frame_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_early: got %b want 0", frame_valid);
    end
    send_sym(1, 0);
    checks++;
    if (frame_valid !== 1'b1 || frame_data !== 8'hA5) begin
      errors++;
      $display("FAIL basic_frame: got v=%b d=%h want 1/a5",
               frame_valid, frame_data);
    end
    checks++;
    if (state !== 2'd3 || dec_en !== 1'b0) begin
      errors++;
      $display("FAIL basic_done: got st=%0d en=%b want 3/0",
               state, dec_en);
    end
    cyc();
    checks++;
    if (frame_valid !== 1'b0 || state !== 2'd1 || dec_en !== 1'b1) begin
      errors++;
      $display("FAIL basic_accept: got v=%b st=%0d en=%b want 0/1/1",
               frame_valid, state, dec_en);
    end
    checks++;
    if (err_pulses !== e0) begin
      errors++;
      $display("FAIL basic_noerr: got %0d want %0d", err_pulses, e0);
    end
  endtask

  task automatic test_overlap();
    int e0;
    e0 = err_pulses;
    send_sym(0, 0); send_sym(1, 0); send_sym(0, 0);
    send_sym(0, 0); send_sym(1, 0); send_sym(0, 0);
    checks++;
    if (state !== 2'd1) begin
      errors++;
      $display("FAIL ovl_nomatch: got %0d want 1", state);
    end
    send_sym(1, 0);
    checks++;
    if (state !== 2'd2) begin
      errors++;
      $display("FAIL ovl_match: got %0d want 2", state);
    end
    send_byte(8'h3C);
    checks++;
    if (frame_valid !== 1'b1 || frame_data !== 8'h3C) begin
      errors++;
      $display("FAIL ovl_frame: got v=%b d=%h want 1/3c",
               frame_valid, frame_data);
    end
    cyc();
    checks++;
    if (err_pulses !== e0 || state !== 2'd1) begin
      errors++;
      $display("FAIL ovl_end: got e=%0d st=%0d want %0d/1",
               err_pulses, state, e0);
    end
  endtask

  task automatic test_timeout();
    int e0;
    e0 = err_pulses;
    send_pre();
    send_sym(1, 0); send_sym(0, 0); send_sym(1, 0);
    idle(30);
    checks++;
    if (frame_err !== 1'b0 || state !== 2'd2) begin
      errors++;
      $display("FAIL tmo_early: got e=%b st=%0d want 0/2",
               frame_err, state);
    end
    idle(1);
    checks++;
    if (frame_err !== 1'b1 || state !== 2'd1) begin
      errors++;
      $display("FAIL tmo_abort: got e=%b st=%0d want 1/1",
               frame_err, state);
    end
    cyc();
    checks++;
    if (frame_err !== 1'b0 || err_pulses !== e0 + 1) begin
      errors++;
      $display("FAIL tmo_pulse: got e=%b n=%0d want 0/%0d",
               frame_err, err_pulses, e0 + 1);
    end
  endtask

  task automatic test_bad_symbol();
    int e0;
    e0 = err_pulses;
    send_pre();
    send_sym(1, 0); send_sym(0, 0); send_sym(1, 0);
    send_sym(1, 1);
    checks++;
    if (frame_err !== 1'b1 || state !== 2'd1) begin
      errors++;
      $display("FAIL bad_abort: got e=%b st=%0d want 1/1",
               frame_err, state);
    end
    cyc();
    checks++;
    if (frame_err !== 1'b0 || err_pulses !== e0 + 1) begin
      errors++;
      $display("FAIL bad_pulse: got e=%b n=%0d want 0/%0d",
               frame_err, err_pulses, e0 + 1);
    end
  endtask

  task automatic test_gap_edge();
    int e0;
    e0 = err_pulses;
    send_pre();
    send_sym(1, 0); send_sym(0, 0); send_sym(1, 0);
    idle(30);
    send_sym(1, 0);
    checks++;
    if (frame_err !== 1'b0 || state !== 2'd2) begin
      errors++;
      $display("FAIL gap_sym: got e=%b st=%0d want 0/2",
               frame_err, state);
    end
    send_sym(0, 0); send_sym(0, 0); send_sym(1, 0); send_sym(1, 0);
    checks++;
    if (frame_valid !== 1'b1 || frame_data !== 8'hB3) begin
      errors++;
      $display("FAIL gap_frame: got v=%b d=%h want 1/b3",
               frame_valid, frame_data);
    end
    cyc();
    checks++;
    if (err_pulses !== e0 || state !== 2'd1) begin
      errors++;
      $display("FAIL gap_end: got e=%0d st=%0d want %0d/1",
               err_pulses, state, e0);
    end
  endtask

  task automatic test_backpressure();
    int bad_cycles;
    bad_cycles = 0;
    frame_ready = 1'b0;
    send_pre();
    send_byte(8'h5A);
    checks++;
    if (frame_valid !== 1'b1 || frame_data !== 8'h5A) begin
      errors++;
      $display("FAIL bp_frame: got v=%b d=%h want 1/5a",
               frame_valid, frame_data);
    end
    for (int i = 0; i < 20; i++) begin
      sym_valid = (i == 3 || i == 8 || i == 13);
      sym_bit = 1'b1;
      cyc();
      sym_valid = 1'b0;
      if (frame_data !== 8'h5A || dec_en !== 1'b0 ||
          frame_valid !== 1'b1 || state !== 2'd3)
        bad_cycles++;
    end
    checks++;
    if (bad_cycles !== 0) begin
      errors++;
      $display("FAIL bp_hold: got %0d unstable cycles want 0",
               bad_cycles);
    end
    checks++;
    if (drop_cnt !== 8'd3) begin
      errors++;
      $display("FAIL bp_drop: got %0d want 3", drop_cnt);
    end
    frame_ready = 1'b1;
    cyc();
    checks++;
    if (frame_valid !== 1'b0 || state !== 2'd1 ||
        frame_data !== 8'h5A) begin
      errors++;
      $display("FAIL bp_accept: got v=%b st=%0d d=%h want 0/1/5a",
               frame_valid, state, frame_data);
    end
  endtask

  task automatic test_enable_payload();
    int e0;
    e0 = err_pulses;
    send_pre();
    send_sym(1, 0); send_sym(1, 0); send_sym(1, 0);
    enable = 1'b0;
    cyc();
    checks++;
    if (state !== 2'd0 || dec_en !== 1'b0) begin
      errors++;
      $display("FAIL en_idle: got st=%0d en=%b want 0/0",
               state, dec_en);
    end
    cyc();
    checks++;
    if (err_pulses !== e0) begin
      errors++;
      $display("FAIL en_noerr: got %0d want %0d", err_pulses, e0);
    end
    enable = 1'b1;
    cyc();
    send_pre();
    send_sym(1, 0); send_sym(1, 0); send_sym(0, 0);
    send_sym(0, 0); send_sym(0, 0); send_sym(0, 0);
    send_sym(1, 0);
    checks++;
    if (frame_valid !== 1'b0) begin
      errors++;
      $display("FAIL en_cnt_clr: got %b want 0", frame_valid);
    end
    send_sym(1, 0);
    checks++;
    if (frame_valid !== 1'b1 || frame_data !== 8'hC3) begin
      errors++;
      $display("FAIL en_frame: got v=%b d=%h want 1/c3",
               frame_valid, frame_data);
    end
    cyc();
  endtask

  task automatic test_enable_done();
    frame_ready = 1'b0;
    send_pre();
    send_byte(8'h96);
    enable = 1'b0;
    cyc();
    checks++;
    if (state !== 2'd3 || frame_valid !== 1'b1 ||
        frame_data !== 8'h96) begin
      errors++;
      $display("FAIL endone_hold: got st=%0d v=%b d=%h want 3/1/96",
               state, frame_valid, frame_data);
    end
    frame_ready = 1'b1;
    cyc();
    checks++;
    if (state !== 2'd0 || frame_valid !== 1'b0 || dec_en !== 1'b0) begin
      errors++;
      $display("FAIL endone_idle: got st=%0d v=%b en=%b want 0/0/0",
               state, frame_valid, dec_en);
    end
  endtask

  task automatic test_async_reset();
    enable = 1'b1;
    cyc();
    send_pre();
    send_sym(1, 0); send_sym(0, 0); send_sym(1, 0);
    checks++;
    if (state !== 2'd2 || drop_cnt !== 8'd3) begin
      errors++;
      $display("FAIL ar_pre: got st=%0d drop=%0d want 2/3",
               state, drop_cnt);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (state !== 2'd0 || dec_en !== 1'b0 || frame_valid !== 1'b0 ||
        frame_err !== 1'b0) begin
      errors++;
      $display("FAIL ar_ctl: got st=%0d en=%b v=%b e=%b want 0/0/0/0",
               state, dec_en, frame_valid, frame_err);
    end
    checks++;
    if (frame_data !== 8'h00 || drop_cnt !== 8'h00) begin
      errors++;
      $display("FAIL ar_data: got d=%h drop=%0d want 00/0",
               frame_data, drop_cnt);
    end
    enable = 1'b0;
    #3;
    rst_n = 1'b1;
    cyc();
    checks++;
    if (state !== 2'd0) begin
      errors++;
      $display("FAIL ar_stay: got %0d want 0", state);
    end
    enable = 1'b1;
    cyc();
    checks++;
    if (state !== 2'd1) begin
      errors++;
      $display("FAIL ar_hunt: got %0d want 1", state);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overlap();
    test_timeout();
    test_bad_symbol();
    test_gap_edge();
    test_backpressure();
    test_enable_payload();
    test_enable_done();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
